// File: rtl/fsm3_pkg.sv
// ============================================================
// fsm3_pkg: shared state encoding and helpers for the fsm3 sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

package fsm3_pkg;

   localparam int unsigned IDX_A = 0;
   localparam int unsigned IDX_B = 1;
   localparam int unsigned IDX_C = 2;
   localparam int unsigned IDX_D = 3;

   localparam logic [3:0] RESET_STATE = 4'b0001;

   typedef enum logic [3:0] {
      ST_A = 4'b0001,
      ST_B = 4'b0010,
      ST_C = 4'b0100,
      ST_D = 4'b1000
   } state_t;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fsm3_next_logic.sv
// ============================================================
// fsm3_next_logic: combinational one-hot next-state equations
// Revision: 1.0
// ============================================================
`default_nettype none

module fsm3_next_logic
   import fsm3_pkg::*;
(
   input  logic [3:0] state,
   input  logic       in,
   output logic [3:0] next_state
);

   always_comb begin
      next_state        = 4'b0000;
      next_state[IDX_A] = (state[IDX_A] | state[IDX_C]) & ~in;
      next_state[IDX_B] = (state[IDX_A] | state[IDX_B] | state[IDX_D]) & in;
      next_state[IDX_C] = (state[IDX_B] | state[IDX_D]) & ~in;
      next_state[IDX_D] = state[IDX_C] & in;
   end

endmodule

`default_nettype wire

// File: rtl/fsm3_onehot_seq.sv
// ============================================================
// fsm3_onehot_seq: qualified one-hot sequencer with load, match count, err
// Revision: 1.0
// ============================================================
`default_nettype none

module fsm3_onehot_seq
   import fsm3_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               in,
   input  logic               load,
   input  logic [3:0]         load_state,
   input  logic               count_clr,
   output logic [3:0]         state,
   output logic               out,
   output logic [COUNT_W-1:0] match_count,
   output logic               err
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [3:0]         step_next;
   logic               inc;

   fsm3_next_logic u_next (
      .state      (state_q),
      .in         (in),
      .next_state (step_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= state_t'(RESET_STATE);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Load beats step; only a genuine C->D step is counted, never a load into D.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      inc     = 1'b0;
      if (load) begin
         if (is_onehot(load_state)) begin
            state_d = state_t'(load_state);
         end else begin
            state_d = ST_A;
            err_d   = 1'b1;
         end
      end else if (in_valid) begin
         state_d = state_t'(step_next);
         inc     = state_q[IDX_C] & step_next[IDX_D];
      end
      if (count_clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   assign state       = state_q;
   assign out         = state_q[IDX_D];
   assign match_count = cnt_q;
   assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm3_onehot_seq.sv
// ============================================================
// tb_fsm3_onehot_seq: directed self-checking bench (default and 2-bit counters)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_fsm3_onehot_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_s = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_state = 4'b0000;
   logic       count_clr = 1'b0;

   logic [3:0] state8, state2;
   logic       out8, out2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   logic       err8, err2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fsm3_onehot_seq dut (
      .clk (clk), .reset (reset), .in_valid (in_valid), .in (in_s),
      .load (load), .load_state (load_state), .count_clr (count_clr),
      .state (state8), .out (out8), .match_count (cnt8), .err (err8)
   );

   fsm3_onehot_seq #(.COUNT_W(2)) dut2 (
      .clk (clk), .reset (reset), .in_valid (in_valid), .in (in_s),
      .load (load), .load_state (load_state), .count_clr (count_clr),
      .state (state2), .out (out2), .match_count (cnt2), .err (err2)
   );

   // Apply current inputs for one rising edge, then sample 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
      reset = 1'b0; load = 1'b0; count_clr = 1'b0; in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; cyc();
   endtask

   task automatic step(input logic b);
      in_valid = 1'b1; in_s = b; cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b1; load_state = 4'b1000; in_valid = 1'b1; in_s = 1'b1;
      cyc();
      total++;
      if (state8 !== 4'b0001 || out8 !== 1'b0 || cnt8 !== 8'd0 || err8 !== 1'b0) begin
         bad++;
         $display("FAIL reset st=%b out=%b cnt=%0d err=%b exp st=0001 out=0 cnt=0 err=0",
                  state8, out8, cnt8, err8);
      end
      total++;
      if (state2 !== 4'b0001 || cnt2 !== 2'd0 || err2 !== 1'b0) begin
         bad++;
         $display("FAIL reset_w2 st=%b cnt=%0d err=%b exp st=0001 cnt=0 err=0", state2, cnt2, err2);
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp_st [3];
      logic       pat    [3];
      exp_st = '{4'b0010, 4'b0100, 4'b1000};
      pat    = '{1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(pat[i]);
         total++;
         if (state8 !== exp_st[i]) begin
            bad++;
            $display("FAIL basic_step%0d st=%b exp=%b", i, state8, exp_st[i]);
         end
      end
      total++;
      if (out8 !== 1'b1 || cnt8 !== 8'd1 || cnt2 !== 2'd1) begin
         bad++;
         $display("FAIL basic_match out=%b cnt=%0d cnt2=%0d exp out=1 cnt=1", out8, cnt8, cnt2);
      end
   endtask

   task automatic test_hold();
      // continues from D with count 1
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++;
         if (state8 !== 4'b1000 || out8 !== 1'b1 || cnt8 !== 8'd1) begin
            bad++;
            $display("FAIL hold%0d st=%b out=%b cnt=%0d exp st=1000 out=1 cnt=1", i, state8, out8, cnt8);
         end
      end
      step(1'b1);
      total++;
      if (state8 !== 4'b0010 || out8 !== 1'b0 || cnt8 !== 8'd1) begin
         bad++;
         $display("FAIL leave_d st=%b out=%b cnt=%0d exp st=0010 out=0 cnt=1", state8, out8, cnt8);
      end
   endtask

   task automatic test_load();
      logic [9:0] pat;
      pat = 10'b1011010011;
      do_reset();
      load = 1'b1; load_state = 4'b0100; cyc();
      total++;
      if (state8 !== 4'b0100 || err8 !== 1'b0) begin
         bad++;
         $display("FAIL load_c st=%b err=%b exp st=0100 err=0", state8, err8);
      end
      load = 1'b1; load_state = 4'b0110; cyc();
      total++;
      if (state8 !== 4'b0001 || err8 !== 1'b1) begin
         bad++;
         $display("FAIL load_bad st=%b err=%b exp st=0001 err=1", state8, err8);
      end
      for (int i = 0; i < 10; i++) begin
         step(pat[i]);
         total++;
         if (err8 !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky%0d err=%b exp=1", i, err8);
         end
      end
      do_reset();
      total++;
      if (err8 !== 1'b0) begin
         bad++;
         $display("FAIL err_reset err=%b exp=0", err8);
      end
      load = 1'b1; load_state = 4'b0000; cyc();
      total++;
      if (state8 !== 4'b0001 || err8 !== 1'b1) begin
         bad++;
         $display("FAIL load_zero st=%b err=%b exp st=0001 err=1", state8, err8);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp2 [5];
      exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int s = 0; s < 5; s++) begin
         step(1'b1); step(1'b0); step(1'b1);
         total++;
         if (cnt2 !== exp2[s] || cnt8 !== 8'(s + 1) || state2 !== 4'b1000) begin
            bad++;
            $display("FAIL sat_seq%0d cnt2=%0d cnt8=%0d st=%b exp cnt2=%0d cnt8=%0d st=1000",
                     s, cnt2, cnt8, state2, exp2[s], s + 1);
         end
      end
      step(1'b1); step(1'b0);
      count_clr = 1'b1; step(1'b1);
      total++;
      if (cnt2 !== 2'd0 || cnt8 !== 8'd0 || state2 !== 4'b1000) begin
         bad++;
         $display("FAIL clr_wins cnt2=%0d cnt8=%0d st=%b exp cnt=0 st=1000", cnt2, cnt8, state2);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_st [5];
      logic [7:0] exp_c  [5];
      logic       pat    [5];
      exp_st = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
      exp_c  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
      pat    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(pat[i]);
         total++;
         if (state8 !== exp_st[i] || cnt8 !== exp_c[i]) begin
            bad++;
            $display("FAIL b2b%0d st=%b cnt=%0d exp st=%b cnt=%0d", i, state8, cnt8, exp_st[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_load_priority();
      do_reset();
      step(1'b1); step(1'b0);
      load = 1'b1; load_state = 4'b1000; in_valid = 1'b1; in_s = 1'b0;
      cyc();
      total++;
      if (state8 !== 4'b1000 || out8 !== 1'b1 || cnt8 !== 8'd0 || err8 !== 1'b0) begin
         bad++;
         $display("FAIL load_over_step st=%b out=%b cnt=%0d err=%b exp st=1000 out=1 cnt=0 err=0",
                  state8, out8, cnt8, err8);
      end
   endtask

   task automatic test_reset_override();
      do_reset();
      step(1'b1); step(1'b0); step(1'b1); step(1'b0);
      reset = 1'b1; load = 1'b1; load_state = 4'b0100; count_clr = 1'b1;
      in_valid = 1'b1; in_s = 1'b1;
      cyc();
      total++;
      if (state8 !== 4'b0001 || out8 !== 1'b0 || cnt8 !== 8'd0) begin
         bad++;
         $display("FAIL reset_override st=%b out=%b cnt=%0d exp st=0001 out=0 cnt=0", state8, out8, cnt8);
      end
      step(1'b1);
      total++;
      if (state8 !== 4'b0010) begin
         bad++;
         $display("FAIL after_reset st=%b exp=0010", state8);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_load();
      test_saturate();
      test_back_to_back();
      test_load_priority();
      test_reset_override();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
